// File: rtl/display_scan.sv
// Time-multiplexed scan driver for a bicolor 8x8 LED matrix and an 8-digit 7-segment display.
// Optional macro SCAN_DIM_EN adds a 3-bit brightness input that gates the drive window.
module display_scan #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned FRAME_HZ  = 1000,
  parameter int unsigned BLANK_CYC = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] matrixData,
  input  logic [31:0]  numbersData,
`ifdef SCAN_DIM_EN
  input  logic [2:0]   bright,
`endif
  output logic [7:0]   row_n,
  output logic [7:0]   col_r,
  output logic [7:0]   col_g,
  output logic [7:0]   dig_n,
  output logic [7:0]   seg,
  output logic         frame_start
);

  localparam int unsigned DIV = CLK_HZ / (FRAME_HZ * 8);
  localparam int unsigned CW  = ($clog2(DIV) < 3) ? 3 : $clog2(DIV);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;
  localparam state_e RST_STATE = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [127:0]   shadow_m_q, shadow_m_d;
  logic [31:0]    shadow_n_q, shadow_n_d;
  logic [7:0]     row_n_d, col_r_d, col_g_d, dig_n_d, seg_d;
  logic           frame_start_d;
  logic           latch_c;
  logic           dim_ok_c;
  logic [15:0]    row_bits_c;
  logic [3:0]     nib_c;
`ifdef SCAN_DIM_EN
  logic [2:0]     shadow_b_q, shadow_b_d;
`endif

  function automatic logic [7:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 8'h3F;
      4'h1: hex2seg = 8'h06;
      4'h2: hex2seg = 8'h5B;
      4'h3: hex2seg = 8'h4F;
      4'h4: hex2seg = 8'h66;
      4'h5: hex2seg = 8'h6D;
      4'h6: hex2seg = 8'h7D;
      4'h7: hex2seg = 8'h07;
      4'h8: hex2seg = 8'h7F;
      4'h9: hex2seg = 8'h6F;
      4'hA: hex2seg = 8'h77;
      4'hB: hex2seg = 8'h7C;
      4'hC: hex2seg = 8'h39;
      4'hD: hex2seg = 8'h5E;
      4'hE: hex2seg = 8'h79;
      default: hex2seg = 8'h00;
    endcase
  endfunction

  // Slot counter and row/digit index; frames latch at the start of slot 0.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
    latch_c       = (cnt_q == '0) && (idx_q == 3'd0);
    frame_start_d = latch_c;
    shadow_m_d    = latch_c ? matrixData  : shadow_m_q;
    shadow_n_d    = latch_c ? numbersData : shadow_n_q;
  end

`ifdef SCAN_DIM_EN
  assign shadow_b_d = latch_c ? bright : shadow_b_q;
  assign dim_ok_c   = (cnt_q[2:0] <= shadow_b_q);
`else
  assign dim_ok_c   = 1'b1;
`endif

  assign row_bits_c = shadow_m_q[{idx_q, 4'b0000} +: 16];
  assign nib_c      = shadow_n_q[{idx_q, 2'b00} +: 4];

  // BLANK/DRIVE phase tracks cnt; outputs are blank unless driving.
  always_comb begin
    state_d = (cnt_d >= CW'(BLANK_CYC)) ? ST_DRIVE : ST_BLANK;
    row_n_d = 8'hFF;
    dig_n_d = 8'hFF;
    col_r_d = 8'h00;
    col_g_d = 8'h00;
    seg_d   = 8'h00;
    if (state_q == ST_DRIVE && dim_ok_c) begin
      row_n_d = ~(8'd1 << idx_q);
      dig_n_d = ~(8'd1 << idx_q);
      seg_d   = hex2seg(nib_c);
      for (int c = 0; c < 8; c++) begin
        col_r_d[c] = row_bits_c[2*c+1];
        col_g_d[c] = row_bits_c[2*c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shadow_m_q  <= '0;
      shadow_n_q  <= 32'hFFFF_FFFF;
      row_n       <= 8'hFF;
      dig_n       <= 8'hFF;
      col_r       <= 8'h00;
      col_g       <= 8'h00;
      seg         <= 8'h00;
      frame_start <= 1'b0;
`ifdef SCAN_DIM_EN
      shadow_b_q  <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_m_q  <= shadow_m_d;
      shadow_n_q  <= shadow_n_d;
      row_n       <= row_n_d;
      dig_n       <= dig_n_d;
      col_r       <= col_r_d;
      col_g       <= col_g_d;
      seg         <= seg_d;
      frame_start <= frame_start_d;
`ifdef SCAN_DIM_EN
      shadow_b_q  <= shadow_b_d;
`endif
    end
  end

endmodule
